// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode driver for FIELDS decimal fields of DPF digits each.
// A round-robin double-dabble engine fills per-field BCD registers that the scan path reads.
module seg_scan_mux #(
   parameter int FIELDS   = 4,
   parameter int DPF      = 2,
   parameter int VAL_W    = 8,
   parameter int SCAN_DIV = 8192,
   parameter int LZS      = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    power,
   input  logic [FIELDS*VAL_W-1:0] values,
   input  logic [FIELDS-1:0]       field_en,
   input  logic [FIELDS-1:0]       blink_mask,
   input  logic                    blink_tick,
   input  logic [FIELDS*DPF-1:0]   dp,
   output logic [7:0]              seg,
   output logic [FIELDS*DPF-1:0]   an,
   output logic                    conv_done
);

   localparam int DIGITS  = FIELDS * DPF;
   localparam int NIB_EST = (VAL_W * 30103 + 99999) / 100000 + 1;
   localparam int NIB     = (NIB_EST > DPF + 1) ? NIB_EST : DPF + 1;
   localparam int FW      = (FIELDS > 1) ? $clog2(FIELDS) : 1;
   localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW      = $clog2(VAL_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE} state_t;

   state_t                         state_q, state_d;
   logic                           load_en, shift_en, store_en;
   logic [VAL_W-1:0]               sh_q;
   logic [NIB*4-1:0]               acc_q, acc_adj;
   logic [CW-1:0]                  cnt_q;
   logic [FW-1:0]                  fld_q;
   logic [FIELDS-1:0][DPF*4-1:0]   disp_q;
   logic [FIELDS-1:0]              ovf_q, valid_q;

   logic [PW-1:0]                  presc_q, presc_d;
   logic [IW-1:0]                  idx_q, idx_d;
   logic                           phase_q;
   logic [7:0]                     seg_q, seg_d, code_c;
   logic                           blank_c;
   logic [DIGITS-1:0]              an_q, an_d;

   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_LOAD;
         S_LOAD:  state_d = S_SHIFT;
         S_SHIFT: if (cnt_q == CW'(VAL_W - 1)) state_d = S_STORE;
         S_STORE: state_d = S_LOAD;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      load_en   = (state_q == S_LOAD);
      shift_en  = (state_q == S_SHIFT);
      store_en  = (state_q == S_STORE);
      conv_done = store_en;
   end

   // Double-dabble correction: any nibble >= 5 gets +3 before the left shift.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < NIB; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         fld_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= '0;
         valid_q <= '0;
      end else begin
         if (load_en) begin
            sh_q  <= values[fld_q*VAL_W +: VAL_W];
            acc_q <= '0;
            cnt_q <= '0;
         end
         if (shift_en) begin
            acc_q <= (acc_adj << 1) | {{(NIB*4-1){1'b0}}, sh_q[VAL_W-1]};
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q + CW'(1);
         end
         if (store_en) begin
            disp_q[fld_q]  <= acc_q[DPF*4-1:0];
            ovf_q[fld_q]   <= |acc_q[NIB*4-1:DPF*4];
            valid_q[fld_q] <= 1'b1;
            fld_q          <= (fld_q == FW'(FIELDS - 1)) ? '0 : fld_q + FW'(1);
         end
      end
   end

   always_comb begin
      presc_d = (presc_q == PW'(SCAN_DIV - 1)) ? '0 : presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PW'(SCAN_DIV - 1)) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
   end

   // Segments and anodes are both built from idx_d so they change on the same edge.
   always_comb begin
      code_c  = 8'hFF;
      blank_c = 1'b1;
      for (int f = 0; f < FIELDS; f++) begin
         for (int p = 0; p < DPF; p++) begin
            if (idx_d == IW'(f*DPF + p)) begin
               if (!valid_q[f] || !field_en[f] || (blink_mask[f] && phase_q)) begin
                  code_c  = 8'hFF;
                  blank_c = 1'b1;
               end else if (ovf_q[f]) begin
                  code_c  = 8'hBF;
                  blank_c = 1'b0;
               end else if (LZS != 0 && p != 0 && (disp_q[f] >> (4*p)) == '0) begin
                  code_c  = 8'hFF;
                  blank_c = 1'b1;
               end else begin
                  code_c  = seg7(disp_q[f][4*p +: 4]);
                  blank_c = 1'b0;
               end
            end
         end
      end
      if (!blank_c && dp[idx_d]) code_c[7] = 1'b0;
      seg_d = power ? code_c : 8'hFF;
      an_d  = power ? ~(DIGITS'(1) << idx_d) : '1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_q <= '0;
         idx_q   <= '0;
         phase_q <= 1'b0;
         seg_q   <= 8'hFF;
         an_q    <= '1;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         if (blink_tick) phase_q <= ~phase_q;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: cycle-accurate arithmetic reference model, vector table and corner sequences.
module tb_seg_scan_mux;

   localparam int FIELDS = 4;
   localparam int DPF    = 2;
   localparam int VAL_W  = 8;
   localparam int SD     = 4;
   localparam int DIG    = FIELDS * DPF;
   localparam int CONV   = VAL_W + 2;
   localparam int LIM    = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        power = 1'b1;
   logic        blink_tick = 1'b0;
   logic [31:0] values;
   logic [3:0]  field_en, blink_mask;
   logic [7:0]  dp, seg, an;
   logic        conv_done;

   int n_tests = 0;
   int n_fail  = 0;

   int         m_t;
   int         m_samp [FIELDS];
   int         m_val [FIELDS];
   bit         m_valid [FIELDS];
   bit         m_phase;
   logic [7:0] m_seg, m_an;
   logic       m_done;
   logic [7:0] seg_tab [10];

   typedef struct {
      logic [31:0]     vals;
      logic [3:0]      en;
      logic [7:0]      dpv;
      logic [7:0][7:0] exp;
   } vec_t;
   vec_t vecs [7];

   seg_scan_mux #(
      .FIELDS(FIELDS), .DPF(DPF), .VAL_W(VAL_W), .SCAN_DIV(SD), .LZS(1)
   ) dut (
      .clk(clk), .reset(rst_n), .power(power), .values(values),
      .field_en(field_en), .blink_mask(blink_mask), .blink_tick(blink_tick),
      .dp(dp), .seg(seg), .an(an), .conv_done(conv_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d: got %0h expected %0h", name, m_t, act, exp);
      end
   endtask

   // Reference: conversion k samples at cycle 2+CONV*k and commits at CONV*(k+1)+1,
   // the digit shown after cycle t is (t/SD)%DIG, digits derived with / and %.
   task automatic model_edge();
      int idx, f, p, pw, dg;
      logic [7:0] code;
      bit blank;
      if (!rst_n) begin
         m_t = 0;
         m_phase = 0;
         for (int i = 0; i < FIELDS; i++) begin
            m_valid[i] = 0;
            m_val[i] = 0;
         end
         m_seg = 8'hFF;
         m_an = 8'hFF;
         m_done = 1'b0;
         return;
      end
      m_t++;
      idx = (m_t / SD) % DIG;
      f = idx / DPF;
      p = idx % DPF;
      pw = 1;
      for (int i = 0; i < p; i++) pw = pw * 10;
      blank = 0;
      code = 8'hFF;
      if (!m_valid[f] || !field_en[f] || (blink_mask[f] && m_phase)) blank = 1;
      else if (m_val[f] >= LIM) code = 8'hBF;
      else if (p > 0 && m_val[f] < pw) blank = 1;
      else begin
         dg = (m_val[f] / pw) % 10;
         code = seg_tab[dg];
      end
      if (!blank && dp[idx]) code[7] = 1'b0;
      if (power) begin
         m_seg = code;
         m_an = ~(8'h01 << idx);
      end else begin
         m_seg = 8'hFF;
         m_an = 8'hFF;
      end
      m_done = (m_t >= CONV) && ((m_t - CONV) % CONV == 0);
      if (m_t >= 2 && (m_t - 2) % CONV == 0) begin
         f = ((m_t - 2) / CONV) % FIELDS;
         m_samp[f] = int'(values[f*VAL_W +: VAL_W]);
      end
      if (m_t >= CONV + 1 && (m_t - CONV - 1) % CONV == 0) begin
         f = ((m_t - CONV - 1) / CONV) % FIELDS;
         m_val[f] = m_samp[f];
         m_valid[f] = 1;
      end
      if (blink_tick) m_phase = !m_phase;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("seg", seg, m_seg);
      check("an", an, m_an);
      check("conv_done", conv_done, m_done);
   endtask

   task automatic wait_digit(input int d);
      int n = 0;
      do begin
         tick();
         n++;
      end while (((m_t / SD) % DIG) != d && n < 64);
      if (((m_t / SD) % DIG) != d) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_digit: digit %0d not reached within 64 cycles", d);
      end
   endtask

   task automatic pulse_blink();
      blink_tick = 1'b1;
      tick();
      blink_tick = 1'b0;
   endtask

   initial begin
      int first_done, first_an, n;
      logic [7:0] exp_an;
      seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      vecs[0] = '{{8'd99, 8'd7, 8'd45, 8'd30},  4'hF, 8'h00,
                  {8'h90, 8'h90, 8'hFF, 8'hF8, 8'h99, 8'h92, 8'hB0, 8'hC0}};
      vecs[1] = '{{8'd99, 8'd7, 8'd45, 8'd150}, 4'hF, 8'h00,
                  {8'h90, 8'h90, 8'hFF, 8'hF8, 8'h99, 8'h92, 8'hBF, 8'hBF}};
      vecs[2] = '{{8'd99, 8'd7, 8'd45, 8'd0},   4'hF, 8'h00,
                  {8'h90, 8'h90, 8'hFF, 8'hF8, 8'h99, 8'h92, 8'hFF, 8'hC0}};
      vecs[3] = '{{8'd99, 8'd7, 8'd45, 8'd30},  4'b1011, 8'h11,
                  {8'h90, 8'h90, 8'hFF, 8'hFF, 8'h99, 8'h92, 8'hB0, 8'h40}};
      vecs[4] = '{{8'd99, 8'd7, 8'd45, 8'd150}, 4'hF, 8'h02,
                  {8'h90, 8'h90, 8'hFF, 8'hF8, 8'h99, 8'h92, 8'h3F, 8'hBF}};
      vecs[5] = '{{8'd0, 8'd100, 8'd9, 8'd255}, 4'hF, 8'h00,
                  {8'hFF, 8'hC0, 8'hBF, 8'hBF, 8'hFF, 8'h90, 8'hBF, 8'hBF}};
      vecs[6] = '{{8'd99, 8'd7, 8'd45, 8'd30},  4'hF, 8'hA0,
                  {8'h10, 8'h90, 8'hFF, 8'hF8, 8'h99, 8'h92, 8'hB0, 8'hC0}};

      values = vecs[0].vals;
      field_en = 4'hF;
      blink_mask = 4'h0;
      dp = 8'h00;

      // Reset and first conversion / first digit change timing
      repeat (5) tick();
      check("rst_seg", seg, 8'hFF);
      check("rst_an", an, 8'hFF);
      check("rst_conv_done", conv_done, 1'b0);
      rst_n = 1'b1;
      first_done = -1;
      first_an = -1;
      repeat (20) begin
         tick();
         if (conv_done === 1'b1 && first_done < 0) first_done = m_t;
         if (an !== 8'hFE && first_an < 0) first_an = m_t;
      end
      check("first_conv_done_cycle", first_done, CONV);
      check("first_digit_change_cycle", first_an, SD);

      // Vector table
      foreach (vecs[i]) begin
         values = vecs[i].vals;
         field_en = vecs[i].en;
         dp = vecs[i].dpv;
         repeat (60) tick();
         for (int d = 0; d < DIG; d++) begin
            wait_digit(d);
            exp_an = ~(8'h01 << d);
            check($sformatf("vec%0d_seg_d%0d", i, d), seg, vecs[i].exp[d]);
            check($sformatf("vec%0d_an_d%0d", i, d), an, exp_an);
         end
      end

      // Blink and blanking
      values = vecs[0].vals;
      field_en = 4'hF;
      dp = 8'h00;
      repeat (60) tick();
      blink_mask = 4'b0010;
      pulse_blink();
      wait_digit(2); check("blink_on_d2", seg, 8'hFF);
      wait_digit(3); check("blink_on_d3", seg, 8'hFF);
      wait_digit(4); check("blink_on_d4", seg, 8'hF8);
      wait_digit(0); check("blink_on_d0", seg, 8'hC0);
      pulse_blink();
      wait_digit(2); check("blink_off_d2", seg, 8'h92);
      wait_digit(3); check("blink_off_d3", seg, 8'h99);
      field_en = 4'b1011;
      dp = 8'h10;
      pulse_blink();
      wait_digit(2); check("blink_en_d2", seg, 8'hFF);
      wait_digit(4); check("disabled_dp_d4", seg, 8'hFF);
      wait_digit(5); check("disabled_d5", seg, 8'hFF);
      blink_mask = 4'h0;
      field_en = 4'hF;
      dp = 8'h00;
      pulse_blink();

      // Power gating keeps the scan running
      repeat (3) tick();
      power = 1'b0;
      tick();
      check("pwr_off_seg", seg, 8'hFF);
      check("pwr_off_an", an, 8'hFF);
      repeat (9) tick();
      power = 1'b1;
      tick();
      exp_an = ~(8'h01 << ((m_t / SD) % DIG));
      check("pwr_on_an", an, exp_an);
      check("pwr_on_seg", seg, vecs[0].exp[(m_t / SD) % DIG]);

      // Reset in the middle of field 2's shift phase
      n = 0;
      while (!(m_t >= 2 && ((m_t - 2) / CONV) % FIELDS == 2 && (m_t - 2) % CONV == 5) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         n_tests++;
         n_fail++;
         $display("FAIL reach_field2_shift: not reached within 200 cycles");
      end
      rst_n = 1'b0;
      tick();
      check("rst_mid_seg", seg, 8'hFF);
      check("rst_mid_an", an, 8'hFF);
      check("rst_mid_conv_done", conv_done, 1'b0);
      rst_n = 1'b1;
      while (m_t < 17) tick();
      check("f2_blank_before_store_seg", seg, 8'hFF);
      check("f2_blank_before_store_an", an, 8'hEF);
      while (m_t < 49) tick();
      check("f2_after_store_seg", seg, 8'hF8);

      // Randomized traffic against the reference model
      for (int it = 0; it < 20; it++) begin
         for (int f = 0; f < FIELDS; f++) values[f*VAL_W +: VAL_W] = 8'($urandom_range(0, 255));
         field_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         blink_mask = 4'($urandom);
         dp = 8'($urandom);
         power = ($urandom_range(0, 7) != 0);
         if (it == 10) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         for (int c = 0; c < 40; c++) begin
            blink_tick = ($urandom_range(0, 15) == 0);
            tick();
         end
         blink_tick = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised successor to the panel 7-segment driver: time-multiplexes FIELDS numeric fields of DPF decimal digits each onto one common-anode display.
- Converts each field's binary value to BCD with an internal sequential double-dabble engine; no divide/modulo logic.
- Adds per-field blanking, blink, leading-zero suppression, overflow indication and decimal points.
- Single clock domain. The scan rate comes from an internal prescaler, not a derived clock. Sits between the controller registers and the board pins.

Parameters:
- FIELDS, 4, number of independent numeric fields
- DPF, 2, decimal digits per field; DIGITS = FIELDS*DPF
- VAL_W, 8, binary width of each field value
- SCAN_DIV, 8192, clk cycles each digit is lit (>=2)
- LZS, 1, 1 = suppress leading zeros within a field

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- power  in  1  0 = all segments and anodes off
- values  in  FIELDS*VAL_W  packed binary field values; field i at [i*VAL_W +: VAL_W]
- field_en  in  FIELDS  0 = field blanked
- blink_mask  in  FIELDS  1 = field blinks
- blink_tick  in  1  one-cycle pulse; toggles the blink phase
- dp  in  DIGITS  1 = decimal point lit on that digit
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
- an  out  DIGITS  one-hot-low anode select; an[0] = rightmost digit
- conv_done  out  1  one-cycle pulse when a field's BCD result is stored

Behaviour:
- Reset (reset==0 at posedge clk) applies the following, and aborts any conversion in flight:
  - seg=8'hFF, an=all 1s, conv_done=0
  - prescaler=0, digit index=0, blink phase=0
  - all BCD registers 0, all field-valid flags 0
- Digit mapping: digit d belongs to field d/DPF at weight 10^(d%DPF). Field 0 least-significant digit is at an[0].
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the wrap cycle, the digit index advances mod DIGITS.
  - an and seg are both registered from the same index, so there is zero skew between anode and segment data.
  - First digit change occurs SCAN_DIV cycles after reset release.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF, dash=BF.
  - seg[7] is cleared when dp[d]=1, except when the digit is blanked.
- Blank priority (highest first):
  1. power=0 -> seg=FF and an all 1s
  2. field valid flag 0 -> blank
  3. field_en=0 -> blank
  4. blink_mask=1 and blink phase=1 -> blank
  5. overflow -> dash
  6. LZS=1, digit is a leading zero and not the field's least-significant digit -> blank
  7. otherwise the BCD digit
- Blink phase toggles on each cycle blink_tick=1.
- Conversion engine FSM, round-robin over fields 0..FIELDS-1 continuously:
  - IDLE -> LOAD: always taken when out of reset.
  - LOAD: sample values for the current field into a shift register; clear the BCD accumulator.
  - SHIFT: VAL_W iterations, one per cycle. Each iteration adds 3 to every BCD nibble >=5, then shifts left 1.
  - STORE:
    - Overflow = the converted value needs more than DPF digits (any nibble beyond DPF nonzero). Set the field's overflow flag from this.
    - Write the DPF nibbles and set the field's valid flag.
    - Pulse conv_done.
    - Advance the field index mod FIELDS, then go to LOAD.
  - Per-field latency: VAL_W+2 cycles from LOAD to the conv_done pulse.
  - Full refresh takes FIELDS*(VAL_W+2) cycles.
- Input sampling:
  - A values change is sampled only at that field's LOAD. Displayed data updates atomically per field at STORE, never mid-conversion.
  - BCD/valid registers read by the scan path are separate from the engine's working registers, so the display never shows partial results.
- Sizing: internal BCD accumulator holds ceil(VAL_W*log10(2))+1 nibbles (minimum DPF+1).

Test Plan:
- Reset/idle: hold reset low 5 cycles -> seg=FF, an=FF, conv_done=0. After release, the first conv_done arrives at cycle VAL_W+2=10. No digit shows a numeral before its field's first STORE.
- Conversion/scan: values={8'd99,8'd7,8'd45,8'd30}, LZS=1, all enabled, SCAN_DIV=4. Expected digit sequence, an[0..7]: 0,3,5,4,7,blank,9,9 (codes C0,B0,92,99,F8,FF,90,90). Each digit holds 4 cycles, and an/seg change in the same cycle.
- Overflow: field 0 = 8'd150, DPF=2 -> both field-0 digits show BF. Then set value 8'd0 -> after the next field-0 conv_done, digit 0 shows C0 and digit 1 is blank (LZS).
- Blink/blank: blink_mask[1]=1, pulse blink_tick once -> digits 2,3 show FF while other digits are unchanged. A second pulse restores them. field_en[2]=0 -> digits 4,5 show FF regardless of blink. dp[4]=1 on a blanked digit -> seg stays FF.
- Power: power=0 mid-scan -> seg=FF and an=FF on the next cycle, while the scan counter keeps running. power=1 -> display resumes at the current digit index.
- Reset mid-operation: assert reset during SHIFT of field 2 -> all outputs are back at reset values next cycle. After release, conversion restarts at field 0, and field 2 shows blank until its own STORE.
